wb_arbiter: RTL
===============

# wb_arbiter

Shares the single register-file write port (rd_w, rd, rd_in) between several writeback sources: ALU, load unit, CSR unit, and so on. Each source offers a write through a valid/ready handshake. A round-robin arbiter accepts at most one offer per cycle. The accepted write is registered and driven to the register file on the next clock edge. The block sits between the execute/memory units and the RegFile write port.

## Interface
- XLEN, 32, data width; must equal RegFile XLEN
- NREQ, 3, number of writeback requesters (2..8)
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  requester i offers a write this cycle
- req_rd  in  5*NREQ  destination register of requester i, slice [5*i+4:5*i]
- req_data  in  XLEN*NREQ  write data of requester i, slice [XLEN*i+XLEN-1:XLEN*i]
- req_ready  out  NREQ  one-hot or zero; requester i's offer is accepted this cycle
- rd_w  out  1  register-file write enable (registered)
- rd  out  5  register-file write address (registered)
- rd_in  out  XLEN  register-file write data (registered)

## Operation
- Transfer on requester i occurs when req_valid[i] & req_ready[i] on a rising edge.
- req_ready is combinational from req_valid and the priority pointer ptr.
  - At most one bit of req_ready is set.
  - req_ready is zero when no req_valid bit is set.
- The arbiter never stalls: whenever any req_valid bit is set, exactly one request is granted.
- Round robin:
  - The search starts at index ptr and proceeds ptr, ptr+1, …, wrapping modulo NREQ.
  - The first valid index found is granted.
  - After a grant to index g, ptr <= (g+1) mod NREQ.
  - If nothing is granted, ptr holds.
- Output register on a granted transfer:
  - rd_w <= (granted rd != 0).
  - rd <= granted rd.
  - rd_in <= granted data.
- Writes to x0 are accepted (ready asserted, pointer advances) but produce rd_w=0. rd and rd_in still load.
- With no transfer, rd_w <= 0. rd and rd_in hold their previous values.
- Requesters must hold req_valid, req_rd and req_data stable until accepted. The arbiter does not check this.
- Same-rd collisions between requesters are not merged. Writes reach the register file in grant order, so the later grant wins.
- rd_w/rd/rd_in are also the visible "in-flight writeback" stage; forwarding logic in decode may tap them.

## Timing
- Reset (rst_n=0 at posedge) sets:
  - ptr=0
  - rd_w=0, rd=0, rd_in=0
  - req_ready=0 while rst_n=0, regardless of req_valid
- Latency: grant in cycle N, so rd_w=1 in cycle N+1. The RegFile commits at the end of cycle N+1 and the value is readable in cycle N+2.
- Throughput: one write per cycle sustained. rd_w is a single-cycle pulse per accepted write.
- Reset asserted mid-operation:
  - A pending output-stage write is discarded (rd_w=0 next cycle).
  - No request is accepted in the reset cycle.
- Deassertion: the first cycle with rst_n=1 arbitrates normally from ptr=0.
- Single requester continuously valid: granted every cycle, and ptr cycles to (i+1) after each grant.

## Structure
- Shared package rv_pkg holds:
  - REG_ADDR_W=5
  - XLEN default
  - the x0 index constant, used by RegFile and wb_arbiter
- Sub-module rr_arbiter #(N)
  - Inputs: req[N-1:0], ptr.
  - Outputs: one-hot gnt[N-1:0], gnt_idx.
  - Purely combinational, via double-width rotate/priority encode.
- The ptr register and output stage live in wb_arbiter.

## Test plan
- **Reset:** hold rst_n=0 with req_valid=3'b111 → req_ready=0 and rd_w=0. After release, the first grant goes to req 0.
- **Round-robin fairness:** NREQ=3, all valid every cycle with rd=1,2,3 and data 0x11,0x22,0x33 → grants 0,1,2,0,1,2. Each cycle one cycle later shows rd_w=1 with matching rd/rd_in.
- **Pointer skip:** ptr=1, req_valid=3'b001 → grant 0 and ptr becomes 1. Next cycle req_valid=3'b101 → grant 2.
- **x0 write:** req 1 valid with rd=0, data 0xDEADBEEF → req_ready[1]=1, next cycle rd_w=0, ptr advances to 2.
- **Reset mid-stream:** grant req 2 (rd=5, 0xA5) in cycle N and assert rst_n=0 at that edge → rd_w=0 in N+1 and RegFile x5 unchanged.
- **End-to-end with RegFile:** same-rd collision, req 0 rd=7 0x1 and req 1 rd=7 0x2 both valid from ptr=0 → x7 reads 0x1 then 0x2, ending at 0x2.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared core constants: register address width, default data width, x0 index.
package rv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the request vector is rotated by ptr so the
// search starts there, the lowest set bit is found, and the offset is added back.
module rr_arbiter #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [N-1:0]  rot;
  logic [IW-1:0] off;
  logic [IW:0]   sum;

  // Rotate via double-width shift, priority-encode, and map back to an index mod N.
  always_comb begin
    rot = N'({req, req} >> ptr);
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
    gnt_idx = sum[IW-1:0];
    gnt = '0;
    if (|req) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: picks one offered register-file write per cycle in
// round-robin order and registers it onto the single RegFile write port.
module wb_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREQ = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [REG_ADDR_W*NREQ-1:0] req_rd,
  input  logic [XLEN*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rd_w,
  output logic [REG_ADDR_W-1:0]      rd,
  output logic [XLEN-1:0]            rd_in
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         gnt_idx;
  logic [NREQ-1:0]       gnt;
  logic                  accept;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_data;
  logic                  rd_w_q, rd_w_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       rd_in_q, rd_in_d;

  rr_arbiter #(.N(NREQ)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Nothing is accepted while reset is held, so a request cannot slip through.
  assign req_ready = rst_n ? gnt : '0;
  assign accept    = |req_ready;

  // Select the granted requester's address and data.
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_rd   = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Next pointer and output-stage values; x0 writes load rd/rd_in but never enable.
  always_comb begin
    ptr_d   = ptr_q;
    rd_w_d  = 1'b0;
    rd_d    = rd_q;
    rd_in_d = rd_in_q;
    if (accept) begin
      ptr_d   = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      rd_w_d  = (sel_rd != REG_X0);
      rd_d    = sel_rd;
      rd_in_d = sel_data;
    end
  end

  // Pointer and writeback stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      rd_w_q  <= 1'b0;
      rd_q    <= '0;
      rd_in_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      rd_w_q  <= rd_w_d;
      rd_q    <= rd_d;
      rd_in_q <= rd_in_d;
    end
  end

  assign rd_w  = rd_w_q;
  assign rd    = rd_q;
  assign rd_in = rd_in_q;

endmodule
